// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar.
//   arb_state_e : packet arbiter state (IDLE between packets, LOCKED inside one)
//   rr_pick     : circular priority search over a request mask
package stream_xbar_pkg;

    localparam int MAX_PORTS = 32;
    localparam int MAX_IDX_W = 5;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Returns the first set bit of mask[count-1:0], searching circularly from
    // last_idx+1, or -1 when no bit is set.
    function automatic int rr_pick(input logic [MAX_PORTS-1:0] mask,
                                   input int                   count,
                                   input int                   last_idx);
        int result;
        int idx;
        result = -1;
        idx    = 0;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            if (k <= count && result < 0) begin
                idx = (last_idx + k) % count;
                if (mask[idx[MAX_IDX_W-1:0]]) result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/packet_rr_arbiter.sv
// Round-robin arbiter that stays locked on one requester for a whole packet.
//   clk, rst    : clock, synchronous active-high reset
//   req         : request mask, one bit per master
//   last        : last flag of the currently granted master's beat
//   xfer        : a beat of the granted master is transferred this cycle
//   grant       : granted master index
//   grant_valid : grant is meaningful this cycle
module packet_rr_arbiter
    import stream_xbar_pkg::*;
#(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             last,
    input  logic             xfer,
    output logic [IDX_W-1:0] grant,
    output logic             grant_valid
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    int               pick;

    // Grant selection is kept apart from the next-state logic so the grant
    // never depends on xfer, which is itself derived from the grant.
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        pick        = -1;
        if (state_q == ARB_LOCKED) begin
            // Inside a packet only the owner may proceed, even if it stalls.
            grant       = owner_q;
            grant_valid = req[owner_q];
        end else begin
            pick = rr_pick(MAX_PORTS'(req), N, int'(ptr_q));
            if (pick >= 0) begin
                grant       = IDX_W'(pick);
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (last) begin
                state_d = ARB_IDLE;
                ptr_d   = grant;
            end else if (state_q == ARB_IDLE) begin
                state_d = ARB_LOCKED;
                owner_d = grant;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(N - 1);   // master 0 wins the first round
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: rtl/return_path_unit.sv
// Reverse-direction router of the stream crossbar: routes M master-side
// streams to S slave-side ports by m_id_i, with one packet-locked round-robin
// arbiter and one output register per slave-side port.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   m_data_i/m_id_i      : master payload and target slave-side port
//   m_last_i/m_valid_i   : master end of packet / beat valid
//   m_ready_o            : master beat accepted (or dropped for a bad id)
//   s_data_o/s_dest_o    : routed payload and originating master index
//   s_last_o/s_valid_o   : end of packet / output valid
//   s_ready_i            : downstream ready
module return_path_unit
    import stream_xbar_pkg::*;
#(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_i,
    input  logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] m_id_i,
    input  logic [M_DATA_COUNT-1:0]                  m_last_i,
    input  logic [M_DATA_COUNT-1:0]                  m_valid_i,
    output logic [M_DATA_COUNT-1:0]                  m_ready_o,
    output logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_o,
    output logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_o,
    output logic [S_DATA_COUNT-1:0]                  s_last_o,
    output logic [S_DATA_COUNT-1:0]                  s_valid_o,
    input  logic [S_DATA_COUNT-1:0]                  s_ready_i
);

    localparam int GRANT_W = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1;

    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] req;
    logic [M_DATA_COUNT-1:0]                   drop;
    logic [GRANT_W-1:0] grant       [S_DATA_COUNT];
    logic               grant_valid [S_DATA_COUNT];
    logic               xfer        [S_DATA_COUNT];

    always_comb begin
        req  = '0;
        drop = '0;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            // A beat aimed past the last port is swallowed without routing.
            drop[i] = m_valid_i[i] && (int'(m_id_i[i]) >= S_DATA_COUNT);
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                req[j][i] = m_valid_i[i] && (int'(m_id_i[i]) == j);
            end
        end
    end

    for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_port
        logic stage_free;
        logic sel_last;

        assign stage_free = !s_valid_o[j] || s_ready_i[j];
        assign sel_last   = m_last_i[grant[j]];
        assign xfer[j]    = grant_valid[j] && stage_free;

        packet_rr_arbiter #(.N(M_DATA_COUNT)) u_arb (
            .clk        (clk_i),
            .rst        (rst_i),
            .req        (req[j]),
            .last       (sel_last),
            .xfer       (xfer[j]),
            .grant      (grant[j]),
            .grant_valid(grant_valid[j])
        );
    end

    // A master only ever sees ready from the one port it targets, so the
    // per-port contributions never overlap.
    always_comb begin
        m_ready_o = '0;
        if (!rst_i) begin
            m_ready_o = drop;
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (xfer[j]) m_ready_o[grant[j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_valid_o <= '0;
            s_data_o  <= '0;
            s_dest_o  <= '0;
            s_last_o  <= '0;
        end else begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (xfer[j]) begin
                    s_valid_o[j] <= 1'b1;
                    s_data_o[j]  <= m_data_i[grant[j]];
                    s_dest_o[j]  <= T_DEST_WIDTH'(grant[j]);
                    s_last_o[j]  <= m_last_i[grant[j]];
                end else if (s_ready_i[j]) begin
                    s_valid_o[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_return_path_unit.sv
module tb_return_path_unit;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int M   = 3;
    localparam int IDW = $clog2(S);
    localparam int DW  = $clog2(M);
    localparam int S3  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [M-1:0][W-1:0]    m_data;
    logic [M-1:0][IDW-1:0]  m_id;
    logic [M-1:0]           m_last, m_valid, m_ready;
    logic [S-1:0][W-1:0]    s_data;
    logic [S-1:0][DW-1:0]   s_dest;
    logic [S-1:0]           s_last, s_valid, s_ready;

    return_path_unit #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_data_i(m_data), .m_id_i(m_id), .m_last_i(m_last),
        .m_valid_i(m_valid), .m_ready_o(m_ready),
        .s_data_o(s_data), .s_dest_o(s_dest), .s_last_o(s_last),
        .s_valid_o(s_valid), .s_ready_i(s_ready)
    );

    // Three-port variant: a 2-bit id can name a port that does not exist.
    logic [M-1:0][W-1:0]    o_m_data;
    logic [M-1:0][1:0]      o_m_id;
    logic [M-1:0]           o_m_last, o_m_valid, o_m_ready;
    logic [S3-1:0][W-1:0]   o_s_data;
    logic [S3-1:0][DW-1:0]  o_s_dest;
    logic [S3-1:0]          o_s_last, o_s_valid, o_s_ready;

    return_path_unit #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S3), .M_DATA_COUNT(M)) dut_oor (
        .clk_i(clk), .rst_i(rst),
        .m_data_i(o_m_data), .m_id_i(o_m_id), .m_last_i(o_m_last),
        .m_valid_i(o_m_valid), .m_ready_o(o_m_ready),
        .s_data_o(o_s_data), .s_dest_o(o_s_dest), .s_last_o(o_s_last),
        .s_valid_o(o_s_valid), .s_ready_i(o_s_ready)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per port, the owner of an open packet (-1 when none),
    // the last master served, and the contents of the output register.
    int               owner [S];
    int               ptr   [S];
    logic             mv    [S];
    logic [W-1:0]     md    [S];
    int               mdst  [S];
    logic             ml    [S];
    logic [M-1:0]     exp_ready;

    task automatic model_reset();
        for (int j = 0; j < S; j++) begin
            owner[j] = -1;
            ptr[j]   = M - 1;
            mv[j]    = 1'b0;
            md[j]    = '0;
            mdst[j]  = 0;
            ml[j]    = 1'b0;
        end
    endtask

    // Called at a falling edge with inputs already applied: checks ready,
    // advances one clock, then checks the registered outputs.
    task automatic tick();
        int src [S];
        #1;
        exp_ready = '0;
        for (int j = 0; j < S; j++) src[j] = -1;
        if (!rst) begin
            for (int i = 0; i < M; i++)
                if (m_valid[i] && int'(m_id[i]) >= S) exp_ready[i] = 1'b1;
            for (int j = 0; j < S; j++) begin
                int cand;
                cand = -1;
                if (owner[j] >= 0) begin
                    if (m_valid[owner[j]] && int'(m_id[owner[j]]) == j) cand = owner[j];
                end else begin
                    for (int k = 1; k <= M; k++) begin
                        int i;
                        i = (ptr[j] + k) % M;
                        if (cand < 0 && m_valid[i] && int'(m_id[i]) == j) cand = i;
                    end
                end
                if (cand >= 0 && (!mv[j] || s_ready[j])) begin
                    exp_ready[cand] = 1'b1;
                    src[j] = cand;
                end
            end
        end
        check("m_ready", 32'(m_ready), 32'(exp_ready));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int j = 0; j < S; j++) begin
                if (src[j] >= 0) begin
                    mv[j]   = 1'b1;
                    md[j]   = m_data[src[j]];
                    mdst[j] = src[j];
                    ml[j]   = m_last[src[j]];
                    if (m_last[src[j]]) begin
                        owner[j] = -1;
                        ptr[j]   = src[j];
                    end else begin
                        owner[j] = src[j];
                    end
                end else if (s_ready[j]) begin
                    mv[j] = 1'b0;
                end
            end
        end
        @(negedge clk);
        for (int j = 0; j < S; j++) begin
            check($sformatf("s_valid[%0d]", j), 32'(s_valid[j]), 32'(mv[j]));
            if (mv[j]) begin
                check($sformatf("s_data[%0d]", j), 32'(s_data[j]), 32'(md[j]));
                check($sformatf("s_dest[%0d]", j), 32'(s_dest[j]), 32'(mdst[j]));
                check($sformatf("s_last[%0d]", j), 32'(s_last[j]), 32'(ml[j]));
            end
        end
    endtask

    task automatic set_m(input int i, input logic v, input logic [W-1:0] d,
                         input int id, input logic l);
        m_valid[i] = v;
        m_data[i]  = d;
        m_id[i]    = IDW'(id);
        m_last[i]  = l;
    endtask

    int rem [M];
    int pid [M];
    int fair_dest [4] = '{0, 2, 0, 2};

    initial begin
        model_reset();
        rst = 1'b1;
        m_valid = '1; m_data = '0; m_id = '0; m_last = '1; s_ready = '1;
        o_m_valid = '0; o_m_data = '0; o_m_id = '0; o_m_last = '1; o_s_ready = '1;
        @(negedge clk);

        // Reset held two cycles with every master requesting.
        tick();
        check("rst_ready_lit", 32'(m_ready), 32'h0);
        tick();
        check("rst_valid_lit", 32'(s_valid), 32'h0);
        check("rst_data_lit",  32'(s_data),  32'h0);
        check("rst_dest_lit",  32'(s_dest),  32'h0);
        check("rst_last_lit",  32'(s_last),  32'h0);

        // After release master 0 beats master 1 on port 0.
        rst = 1'b0;
        set_m(0, 1, 8'h01, 0, 1);
        set_m(1, 1, 8'h02, 0, 1);
        set_m(2, 1, 8'h03, 1, 1);
        #1 check("first_grant_lit", 32'(m_ready), 32'h5);
        tick();
        check("first_data0_lit", 32'(s_data[0]), 32'h01);
        check("first_dest1_lit", 32'(s_dest[1]), 32'h2);

        // Single beat from master 1.
        m_valid = '0;
        set_m(1, 1, 8'hA5, 0, 1);
        #1 check("single_ready_lit", 32'(m_ready), 32'h2);
        tick();
        check("single_valid_lit", 32'(s_valid[0]), 32'h1);
        check("single_data_lit",  32'(s_data[0]),  32'hA5);
        check("single_dest_lit",  32'(s_dest[0]),  32'h1);
        check("single_last_lit",  32'(s_last[0]),  32'h1);

        // Fairness: masters 0 and 2 alternate on port 1 every cycle.
        m_valid = '0;
        set_m(0, 1, 8'h30, 1, 1);
        set_m(2, 1, 8'h40, 1, 1);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("fair_valid_lit", 32'(s_valid[1]), 32'h1);
            check("fair_dest_lit",  32'(s_dest[1]),  32'(fair_dest[n]));
        end

        // Packet lock: master 0's three beats go out before master 1's beat.
        m_valid = '0;
        set_m(1, 1, 8'h77, 0, 1);
        for (int b = 0; b < 3; b++) begin
            set_m(0, 1, 8'(8'h10 + b), 0, b == 2);
            tick();
            check("lock_data_lit", 32'(s_data[0]), 32'(8'h10 + b));
            check("lock_dest_lit", 32'(s_dest[0]), 32'h0);
        end
        m_valid[0] = 1'b0;
        tick();
        check("lock_after_data_lit", 32'(s_data[0]), 32'h77);
        check("lock_after_dest_lit", 32'(s_dest[0]), 32'h1);

        // Backpressure on port 0, then release.
        m_valid = '0;
        s_ready = 2'b10;
        set_m(0, 1, 8'h20, 0, 1);
        for (int n = 0; n < 4; n++) begin
            tick();
            check("bp_ready_lit", 32'(m_ready[0]), 32'h0);
            check("bp_hold_lit",  32'(s_data[0]),  32'h77);
        end
        s_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            m_data[0] = 8'(8'h20 + k);
            tick();
            check("bp_resume_lit", 32'(s_data[0]), 32'(8'h20 + k));
        end

        // Parallel delivery and out-of-range drop on the three-port variant.
        m_valid = '0;
        o_m_valid = 3'b111;
        o_m_id[0] = 2'd0; o_m_data[0] = 8'h51;
        o_m_id[1] = 2'd1; o_m_data[1] = 8'h52;
        o_m_id[2] = 2'd3; o_m_data[2] = 8'h53;
        #1 check("oor_ready_lit", 32'(o_m_ready), 32'h7);
        tick();
        check("oor_valid_lit", 32'(o_s_valid), 32'h3);
        check("oor_data0_lit", 32'(o_s_data[0]), 32'h51);
        check("oor_data1_lit", 32'(o_s_data[1]), 32'h52);
        check("oor_dest1_lit", 32'(o_s_dest[1]), 32'h1);
        o_m_valid = 3'b100;
        #1 check("oor_drop_ready_lit", 32'(o_m_ready), 32'h4);
        tick();
        check("oor_drop_valid_lit", 32'(o_s_valid), 32'h0);
        o_m_valid = '0;

        // Randomised traffic against the model, with occasional resets.
        m_valid = '0;
        exp_ready = '0;
        for (int i = 0; i < M; i++) rem[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < M; i++) begin
                if (exp_ready[i] && m_valid[i]) rem[i]--;
                if (!m_valid[i] || exp_ready[i]) begin
                    if (rem[i] <= 0) begin
                        rem[i] = $urandom_range(1, 4);
                        pid[i] = $urandom_range(0, S - 1);
                    end
                    if ($urandom_range(0, 3) != 0)
                        set_m(i, 1, 8'($urandom), pid[i], rem[i] == 1);
                    else
                        m_valid[i] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            for (int j = 0; j < S; j++) s_ready[j] = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/return_path_unit.md
Name: return_path_unit

Overview:
- Reverse-direction router for the stream crossbar.
- Takes M_DATA_COUNT master-side streams, each tagged with the index of a slave-side destination in m_id_i, and routes them back to S_DATA_COUNT slave-side ports.
- Each slave-side port has a round-robin arbiter that is packet-locked until last, followed by a registered output stage.
- Together with the forward arbitration this closes the bidirectional crossbar.

Parameters:
- T_DATA_WIDTH, 8, payload width.
- S_DATA_COUNT, 2, number of slave-side output ports.
- M_DATA_COUNT, 3, number of master-side input ports.
- T_ID___WIDTH (localparam), $clog2(S_DATA_COUNT), width of the routing id.
- T_DEST_WIDTH (localparam), $clog2(M_DATA_COUNT), width of the source tag.

Ports:
- clk_i  in  1  clock; single clock domain, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m_data_i  in  T_DATA_WIDTH x M_DATA_COUNT  master payload.
- m_id_i  in  T_ID___WIDTH x M_DATA_COUNT  target slave-side port.
- m_last_i  in  M_DATA_COUNT  end of packet.
- m_valid_i  in  M_DATA_COUNT  beat valid.
- m_ready_o  out  M_DATA_COUNT  beat accepted.
- s_data_o  out  T_DATA_WIDTH x S_DATA_COUNT  routed payload.
- s_dest_o  out  T_DEST_WIDTH x S_DATA_COUNT  index of the originating master.
- s_last_o  out  S_DATA_COUNT  end of packet.
- s_valid_o  out  S_DATA_COUNT  output valid.
- s_ready_i  in  S_DATA_COUNT  downstream ready.

Behaviour:
- Request: req[j][i] = m_valid_i[i] && (m_id_i[i] == j), for j < S_DATA_COUNT.
- Out-of-range id: m_id_i[i] >= S_DATA_COUNT with m_valid_i[i] gives m_ready_o[i]=1 the same cycle. The beat is dropped and no lock is taken.
- Per output j: stage_free[j] = !s_valid_o[j] || s_ready_i[j].
- Per output j, arbiter FSM states IDLE and LOCKED, plus owner[j] and ptr[j] (last granted master).
- IDLE: grant = first requesting master in circular order starting at ptr[j]+1, chosen combinationally the same cycle.
- LOCKED: grant = owner[j] only; other requesters wait even if the owner's valid drops.
- Transfer: occurs when a grant exists and stage_free[j] is true. In that cycle m_ready_o[grant]=1 and the stage loads data, dest=grant, last.
- Transfer with last=0 from IDLE: go to LOCKED, owner=grant.
- Transfer with last=1: state becomes IDLE and ptr[j]=grant.
- A single-beat packet never enters LOCKED.
- A master is ready only toward the output it targets; m_ready_o is never asserted without m_valid_i.
- Output stage: on load, s_valid_o[j]=1. On s_ready_i[j] with no load, s_valid_o[j]=0. While valid and not ready, all s_*_o[j] hold stable.
- Latency: 1 cycle input to output. Throughput: 1 beat/cycle per output.
- Independent outputs transfer concurrently; different masters may reach different outputs in the same cycle.
- Reset (any cycle, including mid-packet):
  - s_valid_o=0, s_data_o=0, s_dest_o=0, s_last_o=0.
  - All states IDLE, ptr=M_DATA_COUNT-1 so master 0 wins first.
  - m_ready_o forced 0 while rst_i=1.
  - The in-flight output beat and any partial packet are discarded.

Decomposition:
- Package stream_xbar_pkg holds:
  - the arbiter state enum (IDLE, LOCKED);
  - a function for circular priority search over a request mask.
- One sub-module is natural: packet_rr_arbiter (one instance per output). It takes the request mask, last, and transfer strobe, and outputs grant index and grant-valid.
- The output register stage stays inline.

Test Plan (S=2, M=3):
- Reset: hold rst_i 2 cycles with m_valid_i=111 -> m_ready_o=000 and s_valid_o=00 during reset. Master 0 is granted first after release.
- Single beat: m1 sends 0xA5, id=0, last=1, s_ready_i=11 -> m_ready_o=010 that cycle. Next cycle s_valid_o[0]=1, s_data_o[0]=0xA5, s_dest_o[0]=1, s_last_o[0]=1.
- Fairness: m0 and m2 continuously send single-beat packets to id=1 with s_ready_i=11 -> s_dest_o[1] sequence 0,2,0,2 with one beat every cycle.
- Packet lock: m0 sends a 3-beat packet (0x10,0x11,0x12) to id 0 while m1 requests id 0 -> three contiguous beats with dest 0, then m1's beat, with no interleave.
- Backpressure: output 0 full and s_ready_i[0]=0 for 4 cycles -> m_ready_o for the id-0 master stays 0 and s_data_o[0] is stable. On release the stream resumes with no loss or duplication.
- Parallel/out-of-range: m0 to id 0, m1 to id 1, m2 to id 3 in the same cycle -> m_ready_o=111; both outputs valid next cycle and m2's beat is dropped.
